dcpu_mem_arbiter: RTL

//  Shares one single-port synchronous-read memory between three requesters: MR-stage data access (D),
//  IF-stage instruction fetch (I) and debug/loader port (G). Sits between the DCPU core and the unified

---
 rtl/dcpu_mem_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dcpu_mem_arbiter.sv
`timescale 1ns/1ps
// Three-way arbiter (data, fetch, debug) in front of one synchronous-read memory.
// One grant per cycle, registered issue, read data returned two cycles after the grant.
module dcpu_mem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CpuIdle,
    input  logic          DReq,
    input  logic          DWe,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWData,
    output logic          DGnt,
    output logic          DRValid,
    output logic [DW-1:0] DRData,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic          IGnt,
    output logic          IRValid,
    output logic [DW-1:0] IRData,
    input  logic          GReq,
    input  logic          GWe,
    input  logic [AW-1:0] GAddr,
    input  logic [DW-1:0] GWData,
    output logic          GGnt,
    output logic          GRValid,
    output logic [DW-1:0] GRData,
    output logic [AW-1:0] MemAddr,
    output logic          MemWE,
    output logic [DW-1:0] MemDOut,
    input  logic [DW-1:0] MemDIn,
    output logic          Busy
);
    typedef enum logic [1:0] {OWN_D = 2'd0, OWN_I = 2'd1, OWN_G = 2'd2} owner_e;
    typedef enum logic {PREF_I = 1'b0, PREF_G = 1'b1} pref_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]    starve_q, starve_d;
    pref_e         rr_q, rr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_dout_q, mem_dout_d;
    logic          tag1_vld_q, tag1_vld_d;
    owner_e        tag1_own_q, tag1_own_d;
    logic          tag2_vld_q;
    owner_e        tag2_own_q;
    logic          gnt_d, gnt_i, gnt_g, g_elig;

    always_comb begin
        gnt_d      = 1'b0;
        gnt_i      = 1'b0;
        gnt_g      = 1'b0;
        rr_d       = rr_q;
        g_elig     = GReq & CpuIdle;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        mem_we_d   = 1'b0;
        tag1_vld_d = 1'b0;
        tag1_own_d = OWN_D;
        starve_d   = 4'd0;

        // Forced fetch overrides everything; the RR pointer only moves on round-robin grants.
        if (IReq && (starve_q == STARVE_LIM)) begin
            gnt_i = 1'b1;
        end else if (DReq) begin
            gnt_d = 1'b1;
        end else if (rr_q == PREF_I) begin
            if (IReq) begin
                gnt_i = 1'b1;
                rr_d  = PREF_G;
            end else if (g_elig) begin
                gnt_g = 1'b1;
            end
        end else begin
            if (g_elig) begin
                gnt_g = 1'b1;
                rr_d  = PREF_I;
            end else if (IReq) begin
                gnt_i = 1'b1;
            end
        end

        if (gnt_d) begin
            mem_addr_d = DAddr;
            mem_we_d   = DWe;
            mem_dout_d = DWData;
            tag1_vld_d = ~DWe;
            tag1_own_d = OWN_D;
        end else if (gnt_i) begin
            mem_addr_d = IAddr;
            tag1_vld_d = 1'b1;
            tag1_own_d = OWN_I;
        end else if (gnt_g) begin
            mem_addr_d = GAddr;
            mem_we_d   = GWe;
            mem_dout_d = GWData;
            tag1_vld_d = ~GWe;
            tag1_own_d = OWN_G;
        end

        if (IReq && !gnt_i) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            starve_q   <= 4'd0;
            rr_q       <= PREF_I;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_dout_q <= '0;
            tag1_vld_q <= 1'b0;
            tag1_own_q <= OWN_D;
            tag2_vld_q <= 1'b0;
            tag2_own_q <= OWN_D;
        end else begin
            starve_q   <= starve_d;
            rr_q       <= rr_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_dout_q <= mem_dout_d;
            tag1_vld_q <= tag1_vld_d;
            tag1_own_q <= tag1_own_d;
            tag2_vld_q <= tag1_vld_q;
            tag2_own_q <= tag1_own_q;
        end
    end

    // Grants are masked while reset is held so requests during reset are dropped.
    assign DGnt    = gnt_d & RST;
    assign IGnt    = gnt_i & RST;
    assign GGnt    = gnt_g & RST;
    assign MemAddr = mem_addr_q;
    assign MemWE   = mem_we_q;
    assign MemDOut = mem_dout_q;
    assign DRValid = tag2_vld_q && (tag2_own_q == OWN_D);
    assign IRValid = tag2_vld_q && (tag2_own_q == OWN_I);
    assign GRValid = tag2_vld_q && (tag2_own_q == OWN_G);
    assign DRData  = MemDIn;
    assign IRData  = MemDIn;
    assign GRData  = MemDIn;
    assign Busy    = tag1_vld_q | tag2_vld_q;
endmodule
